dmem_arbiter: RTL and testbench

Two-requester arbiter for the single-port 256×16 data memory. It shares the memory between the CPU data port and a host/loader port (debug, program/data preload, result readback). The CPU has strict priority because its pipeline cannot stall. The host uses a req/gnt handshake with a registered read return. The block sits between the CPU `d_*` signals and the data-memory macro.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/host arbiter for the single-port data memory
//
// Ports:
//   clock, reset           : clock, asynchronous active-low reset
//   cpu_*                  : CPU data port; strict priority, zero added latency
//   host_req/we/addr/wdata : host request; held until host_gnt
//   host_gnt               : pulse in the cycle the host access drives memory
//   host_rvalid/rdata      : registered host read return (grant + 2)
//   host_starve            : sticky "host blocked too long" flag
//   mem_*                  : data-memory macro interface
//
// Build option: DMEM_ARB_STARVE_EN enables the starvation counter and the
// host_starve flag; when undefined host_starve is tied low.
module dmem_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          host_starve,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    // The memory read port is shared; the CPU owns whatever comes back.
    assign cpu_rdata   = mem_rdata;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;

    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        host_gnt  = 1'b0;

        // No memory access at all while reset is asserted.
        if (reset) begin
            if (cpu_req) begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end else if (host_req && (state_q != S_RESP)) begin
                mem_en    = 1'b1;
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                host_gnt  = 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_WAIT: begin
                if (host_req) begin
                    if (cpu_req)      state_d = S_WAIT;
                    else if (host_we) state_d = S_IDLE;
                    else              state_d = S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            // mem_rdata in RESP belongs to the host read granted last cycle.
            rvalid_q <= (state_q == S_RESP);
            if (state_q == S_RESP) rdata_q <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] cnt_q, cnt_d;
    logic       starve_q, starve_d;

    always_comb begin
        cnt_d    = cnt_q;
        starve_d = starve_q;
        if (host_gnt || !host_req) begin
            cnt_d = '0;
        end else if ((state_q == S_WAIT) && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
        // Flag is sticky across a withdrawn request; only a grant clears it.
        if (host_gnt)            starve_d = 1'b0;
        else if (cnt_d >= LIMIT) starve_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    assign host_starve = starve_q;
`else
    assign host_starve = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        host_req, host_we;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_gnt, host_rvalid, host_starve;
    logic [15:0] host_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;

    logic [15:0] mem [0:255];

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.AW(8), .DW(16), .STARVE_LIMIT(15)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .host_starve(host_starve),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port synchronous memory: write at edge, read data one cycle later.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        cpu_req = 0; cpu_we = 0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
        host_req = 0; host_we = 0; host_addr = 8'h00; host_wdata = 16'h0000;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h55; cpu_wdata = 16'hDEAD;
        tick(); tick();
        tests++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
            fails++; $display("FAIL reset_mem_gate: mem_en=%b mem_we=%b expected 0 0", mem_en, mem_we);
        end
        tests++;
        if (host_gnt !== 1'b0 || host_rvalid !== 1'b0 || host_starve !== 1'b0 || host_rdata !== 16'h0000) begin
            fails++; $display("FAIL reset_outputs: gnt=%b rvalid=%b starve=%b rdata=%h expected 0 0 0 0000",
                              host_gnt, host_rvalid, host_starve, host_rdata);
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        tests++;
        if (mem_en !== 1'b0 || host_gnt !== 1'b0 || host_rvalid !== 1'b0 || host_rdata !== 16'h0000) begin
            fails++; $display("FAIL idle_after_reset: en=%b gnt=%b rvalid=%b rdata=%h expected 0 0 0 0000",
                              mem_en, host_gnt, host_rvalid, host_rdata);
        end
    endtask

    task automatic test_host_write_read;
        host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 16'hA5A5;
        #1;
        tests++;
        if (host_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 16'hA5A5) begin
            fails++; $display("FAIL host_write_grant: gnt=%b en=%b we=%b addr=%h wdata=%h expected 1 1 1 10 a5a5",
                              host_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        host_req = 1; host_we = 0; host_addr = 8'h10; host_wdata = 16'h0000;
        #1;
        tests++;
        if (host_gnt !== 1'b1 || mem_we !== 1'b0) begin
            fails++; $display("FAIL host_read_grant: gnt=%b we=%b expected 1 0", host_gnt, mem_we);
        end
        tick();
        host_req = 0;
        #1;
        tests++;
        if (host_rvalid !== 1'b0) begin
            fails++; $display("FAIL host_read_early: rvalid=%b expected 0", host_rvalid);
        end
        tick();
        tests++;
        if (host_rvalid !== 1'b1 || host_rdata !== 16'hA5A5) begin
            fails++; $display("FAIL host_read_data: rvalid=%b rdata=%h expected 1 a5a5", host_rvalid, host_rdata);
        end
        tick();
        tests++;
        if (host_rvalid !== 1'b0 || host_rdata !== 16'hA5A5) begin
            fails++; $display("FAIL host_read_hold: rvalid=%b rdata=%h expected 0 a5a5", host_rvalid, host_rdata);
        end
    endtask

    task automatic test_contention;
        int bad = 0;
        host_req = 1; host_we = 0; host_addr = 8'h20;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 16'h1234;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (host_gnt !== 1'b0 || mem_addr !== 8'h20 || mem_we !== 1'b1 || mem_wdata !== 16'h1234) bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL contention_cpu_wins: %0d bad cycles expected 0", bad);
        end
        cpu_req = 0; cpu_we = 0;
        #1;
        tests++;
        if (host_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h20) begin
            fails++; $display("FAIL contention_grant: gnt=%b we=%b addr=%h expected 1 0 20", host_gnt, mem_we, mem_addr);
        end
        tick();
        host_req = 0;
        tick();
        tests++;
        if (host_rvalid !== 1'b1 || host_rdata !== 16'h1234) begin
            fails++; $display("FAIL contention_rdata: rvalid=%b rdata=%h expected 1 1234", host_rvalid, host_rdata);
        end
        tick();
    endtask

    task automatic test_starvation;
        int  bad = 0;
        logic exp_s;
        host_req = 1; host_we = 1; host_addr = 8'h40; host_wdata = 16'h5555;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h00;
        // Cycle 1 enters WAIT; WAIT cycle 15 is cycle 16, flag visible from cycle 17.
        for (int k = 1; k <= 20; k++) begin
            #1;
`ifdef DMEM_ARB_STARVE_EN
            exp_s = (k >= 17);
`else
            exp_s = 1'b0;
`endif
            if (host_starve !== exp_s) begin
                bad++;
                $display("FAIL starve_cycle%0d: starve=%b expected %b", k, host_starve, exp_s);
            end
            tick();
        end
        tests++;
        if (bad != 0) fails++;
        cpu_req = 0;
        #1;
`ifdef DMEM_ARB_STARVE_EN
        exp_s = 1'b1;
`else
        exp_s = 1'b0;
`endif
        tests++;
        if (host_gnt !== 1'b1 || host_starve !== exp_s) begin
            fails++; $display("FAIL starve_grant: gnt=%b starve=%b expected 1 %b", host_gnt, host_starve, exp_s);
        end
        tick();
        host_req = 0;
        #1;
        tests++;
        if (host_starve !== 1'b0) begin
            fails++; $display("FAIL starve_clear: starve=%b expected 0", host_starve);
        end
        tick();
    endtask

    task automatic test_cpu_read_in_resp;
        idle_inputs();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'h0F0F;
        tick();
        idle_inputs();
        host_req = 1; host_we = 0; host_addr = 8'h10;
        #1;
        tests++;
        if (host_gnt !== 1'b1) begin
            fails++; $display("FAIL resp_host_grant: gnt=%b expected 1", host_gnt);
        end
        tick();
        host_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
        #1;
        tests++;
        if (mem_en !== 1'b1 || mem_addr !== 8'h30 || host_gnt !== 1'b0) begin
            fails++; $display("FAIL resp_cpu_drive: en=%b addr=%h gnt=%b expected 1 30 0", mem_en, mem_addr, host_gnt);
        end
        tick();
        cpu_req = 0;
        #1;
        tests++;
        if (cpu_rdata !== 16'h0F0F || host_rvalid !== 1'b1 || host_rdata !== 16'hA5A5) begin
            fails++; $display("FAIL resp_no_corrupt: cpu_rdata=%h rvalid=%b host_rdata=%h expected 0f0f 1 a5a5",
                              cpu_rdata, host_rvalid, host_rdata);
        end
        tick();
    endtask

    task automatic test_reset_in_resp;
        int bad = 0;
        idle_inputs();
        host_req = 1; host_we = 0; host_addr = 8'h30;
        tick();
        host_req = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h31; cpu_wdata = 16'hBEEF;
        reset = 1'b0;
        #1;
        tests++;
        if (mem_en !== 1'b0 || host_rvalid !== 1'b0 || host_rdata !== 16'h0000) begin
            fails++; $display("FAIL reset_in_resp: en=%b rvalid=%b rdata=%h expected 0 0 0000", mem_en, host_rvalid, host_rdata);
        end
        tick();
        idle_inputs();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (host_rvalid !== 1'b0 || host_rdata !== 16'h0000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL reset_resp_abort: %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        idle_inputs();
        test_reset();
        test_host_write_read();
        test_contention();
        test_starvation();
        test_cpu_read_in_resp();
        test_reset_in_resp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
